// File: rtl/ppu_pkg.sv
// Shared definitions for the PE array and post-processing unit:
// default widths, config-byte field offsets and the PPU pack FSM encoding.
package ppu_pkg;

  localparam int unsigned PPU_DATA_BITS = 32;
  localparam int unsigned PPU_LANES     = 4;

  localparam int unsigned CFG_RELU_BIT  = 7;
  localparam int unsigned CFG_SHIFT_LSB = 0;
  localparam int unsigned CFG_SHIFT_W   = 5;

  typedef enum logic {
    ST_EMPTY   = 1'b0,
    ST_PARTIAL = 1'b1
  } ppu_state_e;

endpackage

// File: rtl/ppu_requant.sv
// Combinational requantiser: optional ReLU, rounding arithmetic right shift,
// saturation to int8 and offset to uint8.
module ppu_requant #(
  parameter int unsigned DATA_BITS = 32
) (
  input  logic signed [DATA_BITS-1:0] i_psum,
  input  logic                        i_relu_en,
  input  logic        [4:0]           i_shift,
  output logic        [7:0]           o_byte
);

  localparam logic signed [DATA_BITS:0] MAX_V = (DATA_BITS+1)'(127);
  localparam logic signed [DATA_BITS:0] MIN_V = -(DATA_BITS+1)'(128);

  logic signed [DATA_BITS-1:0] w_x;
  logic signed [DATA_BITS:0]   w_ext;
  logic signed [DATA_BITS:0]   w_rnd;
  logic signed [DATA_BITS:0]   w_sum;
  logic signed [DATA_BITS:0]   w_shr;
  logic        [7:0]           w_clamp;

  // One guard bit keeps the rounding add from overflowing at the top of range.
  always_comb begin
    w_x   = (i_relu_en && i_psum[DATA_BITS-1]) ? '0 : i_psum;
    w_ext = {w_x[DATA_BITS-1], w_x};
    w_rnd = (i_shift == 5'd0) ? '0
                              : ({{DATA_BITS{1'b0}}, 1'b1} << (i_shift - 5'd1));
    w_sum = w_ext + w_rnd;
    w_shr = w_sum >>> i_shift;
    if (w_shr > MAX_V)
      w_clamp = 8'h7F;
    else if (w_shr < MIN_V)
      w_clamp = 8'h80;
    else
      w_clamp = w_shr[7:0];
    o_byte = w_clamp ^ 8'h80;
  end

endmodule

// File: rtl/ppu.sv
// Post-processing unit: requantises signed psums to uint8 and packs LANES
// bytes per output word behind a valid/ready skid-free output register.
module ppu
  import ppu_pkg::*;
#(
  parameter int unsigned DATA_BITS = PPU_DATA_BITS,
  parameter int unsigned LANES     = PPU_LANES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_en,
  input  logic [7:0]           i_config,
  input  logic [DATA_BITS-1:0] opsum,
  input  logic                 opsum_valid,
  input  logic                 opsum_last,
  output logic                 opsum_ready,
  output logic [DATA_BITS-1:0] ofmap,
  output logic [LANES-1:0]     ofmap_keep,
  output logic                 ofmap_last,
  output logic                 ofmap_valid,
  input  logic                 ofmap_ready
);

  localparam int unsigned CW = (LANES > 1) ? $clog2(LANES) : 1;

  ppu_state_e           r_state;
  ppu_state_e           w_state_nxt;
  logic [CW-1:0]        r_lane_cnt;
  logic                 r_relu_en;
  logic [4:0]           r_shift;
  logic [DATA_BITS-1:0] r_pack;
  logic [DATA_BITS-1:0] r_ofmap;
  logic [LANES-1:0]     r_keep;
  logic                 r_last;
  logic                 r_valid;

  logic [7:0]           w_byte;
  logic [DATA_BITS-1:0] w_word;
  logic [LANES-1:0]     w_keep;
  logic                 w_complete;
  logic                 w_ready;
  logic                 w_fire;
  logic                 w_out_hs;
  logic                 w_cfg_load;
  logic                 w_unused_cfg;

  assign w_unused_cfg = ^i_config[CFG_RELU_BIT-1:CFG_SHIFT_LSB+CFG_SHIFT_W];

  ppu_requant #(
    .DATA_BITS(DATA_BITS)
  ) u_requant (
    .i_psum    (opsum),
    .i_relu_en (r_relu_en),
    .i_shift   (r_shift),
    .o_byte    (w_byte)
  );

  assign w_complete = (r_lane_cnt == CW'(LANES - 1)) | opsum_last;
  assign w_ready    = ~w_complete | ~r_valid | ofmap_ready;
  assign w_fire     = opsum_valid & w_ready;
  assign w_out_hs   = r_valid & ofmap_ready;
  assign w_cfg_load = cfg_en & (r_state == ST_EMPTY) & ~r_valid;

  always_comb begin
    w_word = r_pack;
    w_keep = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      if (CW'(k) == r_lane_cnt)
        w_word[8*k +: 8] = w_byte;
      w_keep[k] = (CW'(k) <= r_lane_cnt);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY:   if (w_fire && !w_complete) w_state_nxt = ST_PARTIAL;
      ST_PARTIAL: if (w_fire && w_complete)  w_state_nxt = ST_EMPTY;
      default:    w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_state <= ST_EMPTY;
    else
      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_relu_en <= 1'b0;
      r_shift   <= '0;
    end else if (w_cfg_load) begin
      r_relu_en <= i_config[CFG_RELU_BIT];
      r_shift   <= i_config[CFG_SHIFT_LSB +: CFG_SHIFT_W];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lane_cnt <= '0;
      r_pack     <= '0;
    end else if (w_fire) begin
      if (w_complete) begin
        r_lane_cnt <= '0;
        r_pack     <= '0;
      end else begin
        r_lane_cnt <= r_lane_cnt + CW'(1);
        r_pack     <= w_word;
      end
    end
  end

  // A completing beat may load the output register in the same cycle the
  // previous word leaves, so completion takes priority over the clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ofmap <= '0;
      r_keep  <= '0;
      r_last  <= 1'b0;
      r_valid <= 1'b0;
    end else if (w_fire && w_complete) begin
      r_ofmap <= w_word;
      r_keep  <= w_keep;
      r_last  <= opsum_last;
      r_valid <= 1'b1;
    end else if (w_out_hs) begin
      r_valid <= 1'b0;
    end
  end

  assign opsum_ready = w_ready;
  assign ofmap       = r_ofmap;
  assign ofmap_keep  = r_keep;
  assign ofmap_last  = r_last;
  assign ofmap_valid = r_valid;

endmodule

// File: tb/tb_ppu.sv
// Directed bench for ppu: requant/pack vectors, backpressure, reset mid-word
// and config gating, all checked against hand-computed words.
module tb_ppu;

  logic        clk;
  logic        rst;
  logic        cfg_en;
  logic [7:0]  i_config;
  logic [31:0] opsum;
  logic        opsum_valid;
  logic        opsum_last;
  logic        opsum_ready;
  logic [31:0] ofmap;
  logic [3:0]  ofmap_keep;
  logic        ofmap_last;
  logic        ofmap_valid;
  logic        ofmap_ready;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  ppu #(
    .DATA_BITS(32),
    .LANES(4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_en      (cfg_en),
    .i_config    (i_config),
    .opsum       (opsum),
    .opsum_valid (opsum_valid),
    .opsum_last  (opsum_last),
    .opsum_ready (opsum_ready),
    .ofmap       (ofmap),
    .ofmap_keep  (ofmap_keep),
    .ofmap_last  (ofmap_last),
    .ofmap_valid (ofmap_valid),
    .ofmap_ready (ofmap_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [31:0] v, input logic last);
    bit done;
    done        = 1'b0;
    opsum       = v;
    opsum_last  = last;
    opsum_valid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      if (opsum_ready) done = 1'b1;
      step();
    end
    opsum_valid = 1'b0;
    opsum_last  = 1'b0;
    if (!done) chk("beat_timeout", 32'd0, 32'd1);
  endtask

  task automatic cfg(input logic [7:0] c);
    i_config = c;
    cfg_en   = 1'b1;
    step();
    cfg_en   = 1'b0;
  endtask

  task automatic pop(input string tag, input logic [31:0] w, input logic [3:0] k, input logic l);
    chk({tag, "_valid"}, {31'd0, ofmap_valid}, 32'd1);
    chk({tag, "_data"},  ofmap, w);
    chk({tag, "_keep"},  {28'd0, ofmap_keep}, {28'd0, k});
    chk({tag, "_last"},  {31'd0, ofmap_last}, {31'd0, l});
    ofmap_ready = 1'b1;
    step();
    ofmap_ready = 1'b0;
    chk({tag, "_drained"}, {31'd0, ofmap_valid}, 32'd0);
  endtask

  initial begin
    rst = 1'b0; cfg_en = 1'b0; i_config = '0; opsum = '0;
    opsum_valid = 1'b0; opsum_last = 1'b0; ofmap_ready = 1'b0;
    step(); step();
    chk("rst_valid", {31'd0, ofmap_valid}, 32'd0);
    chk("rst_ofmap", ofmap, 32'd0);
    chk("rst_keep",  {28'd0, ofmap_keep}, 32'd0);
    chk("rst_last",  {31'd0, ofmap_last}, 32'd0);
    rst = 1'b1;
    step();
    chk("rst_ready", {31'd0, opsum_ready}, 32'd1);

    // shift 0, no relu: 1->81, -1->7F, 127->FF, -200->00
    cfg(8'h00);
    send_beat(32'd1, 1'b0);
    send_beat(-32'sd1, 1'b0);
    send_beat(32'd127, 1'b0);
    send_beat(-32'sd200, 1'b0);
    pop("w_basic", 32'h00FF7F81, 4'hF, 1'b0);

    // shift 4, relu: 24->82, -50->80, 4000->FF, 7->80
    cfg(8'h84);
    send_beat(32'd24, 1'b0);
    send_beat(-32'sd50, 1'b0);
    send_beat(32'd4000, 1'b0);
    send_beat(32'd7, 1'b0);
    pop("w_relu", 32'h80FF8082, 4'hF, 1'b0);

    cfg(8'h00);
    send_beat(32'd5, 1'b0);
    send_beat(32'd6, 1'b1);
    pop("w_last", 32'h00008685, 4'h3, 1'b1);

    // Backpressure: word A pending, three beats fill the pack, fourth stalls.
    for (int v = 1; v <= 4; v++) send_beat(32'(v), 1'b0);
    for (int v = 5; v <= 7; v++) send_beat(32'(v), 1'b0);
    chk("bp_a_valid", {31'd0, ofmap_valid}, 32'd1);
    opsum = 32'd8; opsum_valid = 1'b1;
    #1;
    chk("bp_stall_ready", {31'd0, opsum_ready}, 32'd0);
    step();
    chk("bp_a_hold", ofmap, 32'h84838281);
    chk("bp_a_keep", {28'd0, ofmap_keep}, 32'hF);
    chk("bp_still_stall", {31'd0, opsum_ready}, 32'd0);
    ofmap_ready = 1'b1;
    #1;
    chk("bp_release_ready", {31'd0, opsum_ready}, 32'd1);
    step();
    opsum_valid = 1'b0;
    chk("bp_b_valid", {31'd0, ofmap_valid}, 32'd1);
    chk("bp_b_data", ofmap, 32'h88878685);
    step();
    chk("bp_b_drained", {31'd0, ofmap_valid}, 32'd0);
    ofmap_ready = 1'b0;

    // Reset mid-word discards the partial pack and the config.
    cfg(8'h81);
    send_beat(32'd9, 1'b0);
    send_beat(32'd9, 1'b0);
    rst = 1'b0;
    #2;
    chk("mid_rst_valid", {31'd0, ofmap_valid}, 32'd0);
    rst = 1'b1;
    step();
    chk("mid_rst_ready", {31'd0, opsum_ready}, 32'd1);
    for (int i = 0; i < 4; i++) send_beat(32'd2, 1'b0);
    pop("w_after_rst", 32'h82828282, 4'hF, 1'b0);

    // cfg_en ignored while PARTIAL, taken in EMPTY.
    send_beat(32'd16, 1'b0);
    cfg(8'h02);
    for (int i = 0; i < 3; i++) send_beat(32'd16, 1'b0);
    pop("w_cfg_ignored", 32'h90909090, 4'hF, 1'b0);
    cfg(8'h02);
    send_beat(32'd16, 1'b1);
    pop("w_cfg_applied", 32'h00000084, 4'h1, 1'b1);
    send_beat(-32'sd6, 1'b1);
    pop("w_neg_round", 32'h0000007F, 4'h1, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
